// File: rtl/fifo_to_axis.sv
// Drains a sync_fifo read port into an AXI4-Stream master through a 3-entry skid buffer.
// Define FIFO_TO_AXIS_TLAST_EN to enable fixed-length packet framing (tlast / pkt_done).
module fifo_to_axis #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACKET_LEN = 16
) (
  input  logic                  clk,
  input  logic                  s_rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_data_vld,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  pkt_done,
  output logic                  ovf_err
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned PTR_W = 2;

  if ((PACKET_LEN < 1) || (PACKET_LEN > 65535)) begin : g_bad_packet_len
    $error("fifo_to_axis: PACKET_LEN must be in 1..65535");
  end

  logic [DATA_WIDTH-1:0] buf_q [0:DEPTH-1];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [1:0]            count_q;
  logic                  inflight_q;
  logic                  ovf_err_q;
  logic                  push;
  logic                  accept;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Only issue a read when the returning word is guaranteed a free slot.
  assign fifo_rd_en    = !fifo_empty && ((3'(count_q) + 3'(inflight_q)) <= 3'd2);
  assign m_axis_tvalid = (count_q != 2'd0);
  assign m_axis_tdata  = buf_q[rd_ptr_q];
  assign ovf_err       = ovf_err_q;

  // Data returning without a matching read (e.g. straight after reset) is not ours.
  assign push   = fifo_rd_data_vld && inflight_q;
  assign accept = push && (count_q != 2'd3);
  assign pop    = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q[wr_ptr_q] <= fifo_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (accept) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (fifo_rd_data_vld && (count_q == 2'd3)) begin
        ovf_err_q <= 1'b1;
      end
    end
  end

`ifdef FIFO_TO_AXIS_TLAST_EN
  localparam int unsigned BEAT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PACKET_LEN - 1);

  logic [BEAT_W-1:0] beat_cnt_q;
  logic              pkt_done_q;

  assign m_axis_tlast = m_axis_tvalid && (beat_cnt_q == BEAT_LAST);
  assign pkt_done     = pkt_done_q;

  // Beat position within the current packet, advanced per handshake.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      beat_cnt_q <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      pkt_done_q <= pop && m_axis_tlast;
      if (pop) begin
        beat_cnt_q <= (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + BEAT_W'(1);
      end
    end
  end
`else
  assign m_axis_tlast = 1'b0;
  assign pkt_done     = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_to_axis.sv
// Directed bench for fifo_to_axis: cycle-exact vector table plus streaming,
// backpressure, overflow and mid-packet reset sequences against a small FIFO model.
module tb_fifo_to_axis;

  logic       clk;
  logic       s_rst;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_data_vld;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       pkt_done;
  logic       ovf_err;

  fifo_to_axis #(.DATA_WIDTH(8), .PACKET_LEN(16)) dut (
    .clk              (clk),
    .s_rst            (s_rst),
    .fifo_empty       (fifo_empty),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_rd_data_vld (fifo_rd_data_vld),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .pkt_done         (pkt_done),
    .ovf_err          (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: one-cycle read latency, optional stray data-valid injection.
  logic [7:0] fmem [0:255];
  logic [7:0] wr_idx;
  logic [7:0] rd_idx;
  logic       fifo_clr;
  logic       stray;

  assign fifo_empty = (wr_idx == rd_idx);

  always @(posedge clk) begin
    if (fifo_clr) rd_idx <= wr_idx;
    else if (fifo_rd_en) rd_idx <= rd_idx + 8'd1;
    fifo_rd_data     <= fmem[rd_idx];
    fifo_rd_data_vld <= (fifo_rd_en && !fifo_clr) || stray;
  end

  task automatic fifo_push(input logic [7:0] d);
    fmem[wr_idx] = d;
    wr_idx = wr_idx + 8'd1;
  endtask

  // Beat monitor, sampled mid-cycle after inputs have settled.
  logic       mon_en;
  logic [7:0] bd[$];
  logic       bl[$];
  int         bc[$];
  int         cyc = 0;
  int         npkt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last_hs = 1'b0;

  always @(negedge clk) begin
    #2;
    cyc++;
    if (mon_en) begin
      if (prev_stall) chk("stall_hold", {23'd0, m_axis_tvalid, m_axis_tdata}, {23'd0, 1'b1, prev_data});
      if (pkt_done || prev_last_hs) chk("pkt_done_timing", 32'(pkt_done), 32'(prev_last_hs));
      if (pkt_done) npkt++;
      if (m_axis_tvalid && m_axis_tready) begin
        bd.push_back(m_axis_tdata);
        bl.push_back(m_axis_tlast);
        bc.push_back(cyc);
      end
      prev_stall   = m_axis_tvalid && !m_axis_tready;
      prev_data    = m_axis_tdata;
      prev_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    end else begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end
  end

  task automatic clr_mon();
    bd.delete();
    bl.delete();
    bc.delete();
    npkt = 0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #3;
      if (bd.size() >= n) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_beats timeout actual=%0d required=%0d", bd.size(), n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_rst = 1'b1;
    fifo_clr = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    fifo_clr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    chk({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
    chk({tag, "_ovf_err"}, 32'(ovf_err), 32'd0);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
  endtask

  function automatic logic exp_last(input int i);
`ifdef FIFO_TO_AXIS_TLAST_EN
    return (i % 16) == 15;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_pkts(input int beats);
`ifdef FIFO_TO_AXIS_TLAST_EN
    return beats / 16;
`else
    return 0;
`endif
  endfunction

  typedef struct {
    int unsigned npush;
    logic [7:0]  base;
    logic        rdy;
    logic        e_rd;
    logic        e_tv;
    logic [7:0]  e_data;
    logic        e_last;
  } vec_t;

  vec_t vecs [19];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    s_rst = 1'b1;
    fifo_clr = 1'b1;
    stray = 1'b0;
    m_axis_tready = 1'b0;
    wr_idx = 8'd0;
    mon_en = 1'b0;

    // single word, then a 4-word burst behind a 10-cycle stall
    vecs[0]  = '{1, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0};
    vecs[3]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{4, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0};
    for (int i = 7; i < 14; i++) vecs[i] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0};
    vecs[14] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0};
    vecs[15] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0};
    vecs[16] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0};
    vecs[17] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA4, 1'b0};
    vecs[18] = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    s_rst = 1'b0;
    fifo_clr = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_vals("reset");

    foreach (vecs[i]) begin
      @(negedge clk);
      for (int k = 0; k < int'(vecs[i].npush); k++) fifo_push(vecs[i].base + 8'(k));
      m_axis_tready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en), 32'(vecs[i].e_rd));
      chk($sformatf("vec%0d_tvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].e_tv));
      chk($sformatf("vec%0d_tlast", i), 32'(m_axis_tlast), 32'(vecs[i].e_last));
      if (vecs[i].e_tv) chk($sformatf("vec%0d_tdata", i), 32'(m_axis_tdata), 32'(vecs[i].e_data));
    end

    // 32-word stream at full rate
    do_reset();
    clr_mon();
    for (int i = 0; i < 32; i++) fifo_push(8'(i));
    m_axis_tready = 1'b1;
    mon_en = 1'b1;
    wait_beats(32, 200);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("stream_count", 32'(bd.size()), 32'd32);
    for (int i = 0; i < bd.size(); i++) begin
      chk($sformatf("stream_data%0d", i), 32'(bd[i]), 32'(i));
      chk($sformatf("stream_last%0d", i), 32'(bl[i]), 32'(exp_last(i)));
      if (i > 0) chk($sformatf("stream_gap%0d", i), 32'(bc[i] - bc[i-1]), 32'd1);
    end
    chk("stream_pkts", 32'(npkt), 32'(exp_pkts(32)));

    // 20 words under pseudo-random backpressure
    do_reset();
    clr_mon();
    for (int i = 0; i < 20; i++) fifo_push(8'h40 + 8'(i));
    mon_en = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      m_axis_tready = 1'($urandom_range(0, 1));
      #3;
      if (bd.size() >= 20) break;
    end
    @(negedge clk);
    m_axis_tready = 1'b1;
    mon_en = 1'b0;
    chk("bp_count", 32'(bd.size()), 32'd20);
    for (int i = 0; i < bd.size(); i++) chk($sformatf("bp_data%0d", i), 32'(bd[i]), 32'h40 + 32'(i));
    chk("bp_ovf", 32'(ovf_err), 32'd0);

    // stray data-valid while the buffer is full
    do_reset();
    clr_mon();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) fifo_push(8'h60 + 8'(i));
    repeat (6) @(negedge clk);
    #1;
    chk("ovf_before", 32'(ovf_err), 32'd0);
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    #1;
    chk("ovf_set", 32'(ovf_err), 32'd1);
    @(negedge clk);
    m_axis_tready = 1'b1;
    mon_en = 1'b1;
    wait_beats(3, 50);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("ovf_drain_count", 32'(bd.size()), 32'd3);
    for (int i = 0; i < bd.size(); i++) chk($sformatf("ovf_data%0d", i), 32'(bd[i]), 32'h60 + 32'(i));
    chk("ovf_sticky", 32'(ovf_err), 32'd1);

    // reset after beat 5 of a 16-beat packet
    do_reset();
    #1;
    chk("ovf_cleared", 32'(ovf_err), 32'd0);
    clr_mon();
    for (int i = 0; i < 16; i++) fifo_push(8'h80 + 8'(i));
    m_axis_tready = 1'b1;
    mon_en = 1'b1;
    wait_beats(5, 100);
    @(negedge clk);
    m_axis_tready = 1'b0;
    mon_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_beats", 32'(bd.size()), 32'd5);
    @(negedge clk);
    s_rst = 1'b1;
    fifo_clr = 1'b1;
    stray = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    fifo_clr = 1'b0;
    stray = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    @(negedge clk);
    #1;
    chk("post_reset_stray", 32'(m_axis_tvalid), 32'd0);
    clr_mon();
    for (int i = 0; i < 16; i++) fifo_push(8'hC0 + 8'(i));
    m_axis_tready = 1'b1;
    mon_en = 1'b1;
    wait_beats(16, 100);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("pkt2_count", 32'(bd.size()), 32'd16);
    for (int i = 0; i < bd.size(); i++) begin
      chk($sformatf("pkt2_data%0d", i), 32'(bd[i]), 32'hC0 + 32'(i));
      chk($sformatf("pkt2_last%0d", i), 32'(bl[i]), 32'(exp_last(i)));
    end
    chk("pkt2_pkts", 32'(npkt), 32'(exp_pkts(16)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_to_axis.md
# fifo_to_axis

Read-side drain stage for `sync_fifo`: pulls words from the FIFO's read port and presents them as an AXI4-Stream master with optional fixed-length packet framing. The block absorbs the FIFO's one-cycle read latency in a 3-entry output buffer, so it sustains one beat per clock under continuous `m_axis_tready`. There is no combinational path from `m_axis_tready` to `fifo_rd_en`. It sits directly downstream of `sync_fifo` and upstream of any AXI-Stream consumer (DMA, UART TX, etc.).

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width; must match the upstream FIFO.
- `PACKET_LEN`, 16: beats per packet; `m_axis_tlast` is asserted on the last beat. Legal range 1..65535.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `s_rst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO read strobe; combinational from registered state and `fifo_empty`.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO read data; valid when `fifo_rd_data_vld` is high.
- `fifo_rd_data_vld`  in  1  high exactly one cycle after each accepted `fifo_rd_en`.
- `m_axis_tdata`  out  DATA_WIDTH  stream data (buffer head).
- `m_axis_tvalid`  out  1  head entry valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last beat of a packet.
- `pkt_done`  out  1  one-cycle registered pulse after the handshake of a `tlast` beat.
- `ovf_err`  out  1  sticky: `fifo_rd_data_vld` arrived while the buffer was full.

## Operation
- **Buffer:** 3-entry circular buffer with registered write pointer, read pointer and a 2-bit `count` (0..3). Full-throughput design; no bypass path.
- **In-flight tracking:** `inflight` = `fifo_rd_en` registered one cycle.
- **Read issue:** `fifo_rd_en = !fifo_empty && (count + inflight) <= 2`. This guarantees every returning word has a free slot.
- **Push:** on `fifo_rd_data_vld`, write `fifo_rd_data` at the write pointer and advance it.
- **Pop:** on `m_axis_tvalid && m_axis_tready`, advance the read pointer.
- **Count update:** `count` next = `count` + push − pop. Simultaneous push and pop leaves `count` unchanged.
- **Pointer wrap:** pointers wrap 2→0 (modulo 3, not power of two).
- **Stream outputs:** `m_axis_tvalid = (count != 0)`. `m_axis_tdata` = entry at the read pointer.
- **AXI rule:** once `tvalid` is high, `tvalid` and `tdata` stay stable until the handshake. This holds because only a pop changes the head.
- **Beat counter:** `beat_cnt`, width `$clog2(PACKET_LEN)` (minimum 1). It increments on each handshake and wraps to 0 after `PACKET_LEN-1`. `m_axis_tlast = m_axis_tvalid && (beat_cnt == PACKET_LEN-1)`. With `PACKET_LEN=1`, every beat is last.
- **Overflow:** a push while `count==3` drops the word, holds `count` at 3 and sets `ovf_err`. Only a misbehaving FIFO can cause this.
- **Reset:** clears pointers, `count`, `inflight`, `beat_cnt`, `pkt_done` and `ovf_err`. Words in flight are discarded. `fifo_rd_data_vld` in the cycle after reset releases is ignored, because `inflight` is 0.

## Timing
- **Reset values:** `fifo_rd_en` follows `fifo_empty` with `count`/`inflight` at 0. `m_axis_tvalid`, `m_axis_tlast`, `pkt_done` and `ovf_err` are 0. `m_axis_tdata` is don't-care (buffer contents are not cleared).
- **Latency:** `fifo_empty` falls in cycle N → `fifo_rd_en` high in N → `fifo_rd_data_vld` in N+1 → `m_axis_tvalid` high in N+2.
- **Steady state:** with `tready` held high and the FIFO non-empty, `count=1`, `inflight=1`, `fifo_rd_en` high every cycle, one beat per cycle.
- **Downstream stall (`tready` low):**
  - at most 2 further reads issue; `count` settles at 3 and `fifo_rd_en` drops;
  - on release, `fifo_rd_en` re-asserts the cycle `count + inflight` falls to ≤2.
- **`pkt_done`:** high in the cycle after the `tlast` handshake.
- **`s_rst` mid-packet:** the next beat after reset has `beat_cnt=0`.

## Configuration
- `FIFO_TO_AXIS_TLAST_EN` defined: `beat_cnt`, `m_axis_tlast` and `pkt_done` behave as above.
- Undefined:
  - `beat_cnt` is not instantiated;
  - `m_axis_tlast` and `pkt_done` are tied to 0;
  - `PACKET_LEN` is ignored;
  - data path and flow control are unchanged.

## Test plan
- **Single word:** reset, FIFO holds one word 0x5A, `tready=1` → `fifo_rd_en` one cycle, `tvalid` high 2 cycles later for exactly 1 cycle, `tdata=0x5A`.
- **Streaming:** 32 words 0..31, `tready=1`, `PACKET_LEN=16` → 32 consecutive beats with no bubbles; `tlast` on data 15 and 31; `pkt_done` pulses twice.
- **Backpressure:** stream 20 words with `tready` toggling pseudo-randomly →
  - output order intact;
  - `tdata` stable whenever `tvalid && !tready`;
  - `count` never exceeds 3; `ovf_err` stays 0.
- **Long stall:** `tready` low for 10 cycles with the FIFO full → exactly 3 `fifo_rd_en` pulses, then none until `tready` rises.
- **Reset mid-packet:** `s_rst` after beat 5 of 16 → all outputs return to reset values; the next packet's `tlast` is on its 16th beat.
- **Macro off:** build without `FIFO_TO_AXIS_TLAST_EN`, 16 words → identical data beats, `tlast` and `pkt_done` stay 0.
